// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle arithmetic/logic ops and multi-cycle shift-add MUL and bit-serial shifts.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] R_hi,
  output logic             C_out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             ERR
);
  localparam int CW = ($clog2(WIDTH + 1) > SHW) ? $clog2(WIDTH + 1) : SHW;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;
  st_t st_q, st_d;
  logic [WIDTH-1:0] a_q, a_d, r_q, r_d, rhi_q, rhi_d;
  logic [3:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, v_q, v_d, err_q, err_d;
  logic accept, mul_op, sh_op;
  logic [SHW-1:0] amt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0] sum, ms;
  assign amt = B[SHW-1:0];
  assign accept = in_valid & (st_q == IDLE);
  assign mul_op = op == 4'b1000;
  assign sh_op = op inside {4'b1001, 4'b1010, 4'b1011};
  assign addend = op == 4'b0000 ? B : op == 4'b0001 ? ~B : op == 4'b0010 ? '0 : '1;
  assign sum = {1'b0, A} + {1'b0, addend} + {{WIDTH{1'b0}}, C_in};
  // MUL keeps the partial product in {rhi_q, r_q}; r_q starts as the multiplier and drains LSB-first
  assign ms = {1'b0, rhi_q} + {1'b0, a_q & {WIDTH{r_q[0]}}};
  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else st_q <= st_d;
  end
  always_comb begin
    st_d = st_q;
    if (st_q == IDLE && accept) st_d = (mul_op || (sh_op && amt != '0)) ? BUSY : DONE;
    else if (st_q == BUSY && cnt_q == CW'(1)) st_d = DONE;
    else if (st_q == DONE && out_ready) st_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      r_q <= '0;
      rhi_q <= '0;
      op_q <= '0;
      cnt_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      a_q <= a_d;
      r_q <= r_d;
      rhi_q <= rhi_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      c_q <= c_d;
      v_q <= v_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    a_d = a_q;
    r_d = r_q;
    rhi_d = rhi_q;
    op_d = op_q;
    cnt_d = cnt_q;
    c_d = c_q;
    v_d = v_q;
    err_d = err_q;
    if (accept) begin
      a_d = A;
      op_d = op;
      rhi_d = '0;
      c_d = 1'b0;
      v_d = 1'b0;
      err_d = op[3] & op[2];
      cnt_d = mul_op ? CW'(WIDTH) : CW'(amt);
      case (op)
        4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
          r_d = sum[WIDTH-1:0];
          c_d = sum[WIDTH];
          v_d = (A[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        end
        4'b0100: r_d = A & B;
        4'b0101: r_d = A | B;
        4'b0110: r_d = A ^ B;
        4'b0111: r_d = ~A;
        4'b1000: r_d = B;
        4'b1001, 4'b1010, 4'b1011: r_d = A;
        default: r_d = '0;
      endcase
    end else if (st_q == BUSY) begin
      cnt_d = cnt_q - 1'b1;
      if (op_q == 4'b1000) begin
        {rhi_d, r_d} = {ms, r_q[WIDTH-1:1]};
        c_d = |ms[WIDTH:1];
      end else begin
        r_d = op_q == 4'b1001 ? r_q << 1 : op_q == 4'b1010 ? r_q >> 1 : {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        c_d = op_q == 4'b1001 ? r_q[WIDTH-1] : r_q[0];
      end
    end
  end
  always_comb begin
    in_ready = st_q == IDLE;
    out_valid = st_q == DONE;
    R = r_q;
    R_hi = rhi_q;
    C_out = c_q;
    V = v_q;
    ERR = err_q;
    Z = (r_q == '0) && (rhi_q == '0);
    N = op_q == 4'b1000 ? rhi_q[WIDTH-1] : r_q[WIDTH-1];
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;
  localparam int SHW = 3;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, C_in = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0] op = '0;
  logic in_ready, out_valid, C_out, Z, N, V, ERR;
  logic [W-1:0] R, R_hi;
  int total = 0, bad = 0;
  typedef struct {
    longint unsigned r;
    longint unsigned rhi;
    bit c, z, n, v, err;
    int lat;
  } res_t;
  res_t ex, cap;
  bit expecting = 1'b0;
  always #5 clk = ~clk;
  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .op(op),
    .C_in(C_in), .out_valid(out_valid), .out_ready(out_ready), .R(R), .R_hi(R_hi),
    .C_out(C_out), .Z(Z), .N(N), .V(V), .ERR(ERR)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic res_t model(input longint unsigned a, input longint unsigned b, input int o, input bit cin);
    res_t x;
    longint unsigned m, ad, s, p;
    longint sa;
    int amt;
    m = (64'd1 << W) - 1;
    amt = int'(b % (1 << SHW));
    x.r = 0; x.rhi = 0; x.c = 0; x.v = 0; x.err = 0; x.lat = 1;
    sa = a[W-1] ? longint'(a | ~m) : longint'(a);
    case (o)
      0, 1, 2, 3: begin
        ad = o == 0 ? b : o == 1 ? (~b) & m : o == 2 ? 0 : m;
        s = a + ad + cin;
        x.r = s & m;
        x.c = s[W];
        x.v = (a[W-1] == ad[W-1]) && (x.r[W-1] != a[W-1]);
      end
      4: x.r = a & b;
      5: x.r = a | b;
      6: x.r = a ^ b;
      7: x.r = (~a) & m;
      8: begin
        p = a * b;
        x.r = p & m;
        x.rhi = p >> W;
        x.c = x.rhi != 0;
        x.lat = W + 1;
      end
      9: begin
        s = a << amt;
        x.r = s & m;
        x.c = amt != 0 && s[W];
        x.lat = amt + 1;
      end
      10: begin
        x.r = a >> amt;
        x.c = amt != 0 && ((a >> (amt - 1)) & 1) != 0;
        x.lat = amt + 1;
      end
      11: begin
        x.r = longint'(sa >>> amt) & m;
        x.c = amt != 0 && ((sa >>> (amt - 1)) & 1) != 0;
        x.lat = amt + 1;
      end
      default: x.err = 1;
    endcase
    x.z = x.r == 0 && x.rhi == 0;
    x.n = o == 8 ? x.rhi[W-1] : x.r[W-1];
    return x;
  endfunction
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("valid_expected", {63'd0, expecting}, 64'd1);
      if (expecting) begin
        chk("R", R, ex.r);
        chk("R_hi", R_hi, ex.rhi);
        chk("C_out", C_out, ex.c);
        chk("Z", Z, ex.z);
        chk("N", N, ex.n);
        chk("V", V, ex.v);
        chk("ERR", ERR, ex.err);
        chk("in_ready_done", in_ready, 0);
      end
    end
  end
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o, input bit cin, input int hold);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    A = a; B = b; op = o; C_in = cin; in_valid = 1'b1;
    ex = model(a, b, o, cin);
    expecting = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); op = 4'($urandom); C_in = 1'($urandom);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid || lat > W + 20) break;
      chk("in_ready_busy", in_ready, 0);
    end
    chk("latency", lat, ex.lat);
    cap.r = R; cap.rhi = R_hi; cap.c = C_out; cap.z = Z; cap.n = N; cap.v = V; cap.err = ERR; cap.lat = lat;
    repeat (hold) begin
      in_valid = 1'($urandom);
      A = W'($urandom); B = W'($urandom); op = 4'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    expecting = 1'b0;
    @(negedge clk);
    chk("released_valid", out_valid, 0);
  endtask
  initial begin
    res_t m;
    m = model(64'hFF, 64'h01, 0, 0);
    chk("model_add_r", m.r, 64'h00);
    chk("model_add_c", m.c, 1);
    m = model(64'h90, 64'h03, 11, 0);
    chk("model_sar_r", m.r, 64'hF2);
    m = model(64'hFF, 64'hFF, 8, 0);
    chk("model_mul_hi", m.rhi, 64'hFE);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_R", R, 0);
    chk("rst_R_hi", R_hi, 0);
    chk("rst_flags_cnve", {C_out, N, V, ERR}, 0);
    chk("rst_Z", Z, 1);
    run_op(8'hFF, 8'h01, 4'b0000, 1'b0, 0);
    chk("add_R", cap.r, 8'h00);
    chk("add_C", cap.c, 1);
    chk("add_Z", cap.z, 1);
    chk("add_VN", {cap.v, cap.n}, 0);
    chk("add_lat", cap.lat, 1);
    run_op(8'h80, 8'h01, 4'b0001, 1'b1, 1);
    chk("sub_R", cap.r, 8'h7F);
    chk("sub_CVN", {cap.c, cap.v, cap.n}, 3'b110);
    run_op(8'hFF, 8'hFF, 4'b1000, 1'b0, 0);
    chk("mul_lat", cap.lat, 9);
    chk("mul_hi", cap.rhi, 8'hFE);
    chk("mul_lo", cap.r, 8'h01);
    chk("mul_C", cap.c, 1);
    run_op(8'h90, 8'h03, 4'b1011, 1'b0, 5);
    chk("sar_lat", cap.lat, 4);
    chk("sar_R", cap.r, 8'hF2);
    chk("sar_CN", {cap.c, cap.n}, 2'b01);
    run_op(8'h00, 8'h00, 4'b1101, 1'b0, 0);
    chk("ill_ERR", cap.err, 1);
    chk("ill_R", cap.r, 0);
    chk("ill_Z", cap.z, 1);
    run_op(8'h00, 8'h00, 4'b0111, 1'b0, 0);
    chk("not_R", cap.r, 8'hFF);
    chk("not_EN", {cap.err, cap.n}, 2'b01);
    @(negedge clk);
    A = 8'hA5; B = 8'h5A; op = 4'b1000; in_valid = 1'b1;
    ex = model(64'hA5, 64'h5A, 8, 0);
    expecting = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expecting = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_R", R, 0);
    chk("abort_Z", Z, 1);
    run_op(8'h0F, 8'h3C, 4'b0100, 1'b0, 0);
    chk("and_R", cap.r, 8'h0C);
    for (int i = 0; i < 300; i++)
      run_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
